// File: rtl/seg7_name_checker.sv
// seg7_name_checker: receive-side checker for the 7-segment name display.
// Synchronizes the display advance strobe, samples the segment bus on each
// synchronized rising edge, decodes the letter and tracks the 14-symbol frame
// "S E n O L G U L G O n U L blank".
// Optional feature macro: SEG7_DP_CHECK_EN (decimal point set => illegal pattern).
module seg7_name_checker #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       seg_in,
    input  logic             seg_strobe,
    output logic [2:0]       letter_code,
    output logic             letter_valid,
    output logic [3:0]       pos,
    output logic             locked,
    output logic             frame_done,
    output logic [7:0]       frame_count,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned POS_W    = 4;
    localparam int unsigned CODE_W   = 3;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(13);

    localparam logic [CODE_W-1:0] C_BLANK = CODE_W'(0);
    localparam logic [CODE_W-1:0] C_S     = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_E     = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_N     = CODE_W'(3);
    localparam logic [CODE_W-1:0] C_O     = CODE_W'(4);
    localparam logic [CODE_W-1:0] C_L     = CODE_W'(5);
    localparam logic [CODE_W-1:0] C_G     = CODE_W'(6);
    localparam logic [CODE_W-1:0] C_U     = CODE_W'(7);

`ifdef SEG7_DP_CHECK_EN
    localparam bit DP_CHECK = 1'b1;
`else
    localparam bit DP_CHECK = 1'b0;
`endif

    typedef enum logic {HUNT, TRACK} state_t;

    // Expected symbol for each frame index
    function automatic logic [CODE_W-1:0] expected_code(input logic [POS_W-1:0] idx);
        case (idx)
            4'd0:    expected_code = C_S;
            4'd1:    expected_code = C_E;
            4'd2:    expected_code = C_N;
            4'd3:    expected_code = C_O;
            4'd4:    expected_code = C_L;
            4'd5:    expected_code = C_G;
            4'd6:    expected_code = C_U;
            4'd7:    expected_code = C_L;
            4'd8:    expected_code = C_G;
            4'd9:    expected_code = C_O;
            4'd10:   expected_code = C_N;
            4'd11:   expected_code = C_U;
            4'd12:   expected_code = C_L;
            default: expected_code = C_BLANK;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   sync_lvl_c;
    logic                   sample_c;

    assign sync_lvl_c = sync_q[SYNC_STAGES-1];
    assign sample_c   = armed_q & sync_lvl_c & ~prev_q;

    // Strobe synchronizer, edge detector and arm flag (fill_q marks when the chain holds real samples)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seg_strobe};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_lvl_c;
            if (fill_q[SYNC_STAGES-1] && !sync_lvl_c) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic              dec_legal_c;
    logic [CODE_W-1:0] dec_code_c;

    // Segment pattern to letter code
    always_comb begin
        dec_legal_c = 1'b1;
        dec_code_c  = C_BLANK;
        case (seg_in[6:0])
            7'h5B:   dec_code_c = C_S;
            7'h4F:   dec_code_c = C_E;
            7'h15:   dec_code_c = C_N;
            7'h7E:   dec_code_c = C_O;
            7'h0E:   dec_code_c = C_L;
            7'h5F:   dec_code_c = C_G;
            7'h3E:   dec_code_c = C_U;
            7'h00:   dec_code_c = C_BLANK;
            default: dec_legal_c = 1'b0;
        endcase
        if (DP_CHECK && seg_in[7]) begin
            dec_legal_c = 1'b0;
        end
    end

    state_t            state_q, state_d;
    logic [CODE_W-1:0] letter_code_d;
    logic              letter_valid_d;
    logic [POS_W-1:0]  pos_d;
    logic              locked_d;
    logic              frame_done_d;
    logic [7:0]        frame_count_d;
    logic [ERR_W-1:0]  err_count_d;
    logic              is_s_c;

    assign is_s_c = dec_legal_c && (dec_code_c == C_S);

    // Frame tracker next-state and output logic
    always_comb begin
        state_d        = state_q;
        letter_code_d  = letter_code;
        letter_valid_d = 1'b0;
        pos_d          = pos;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count;
        err_count_d    = err_count;
        if (sample_c) begin
            if (dec_legal_c) begin
                letter_code_d  = dec_code_c;
                letter_valid_d = 1'b1;
            end
            case (state_q)
                HUNT: begin
                    if (is_s_c) begin
                        pos_d   = POS_W'(1);
                        state_d = TRACK;
                    end
                end
                default: begin
                    if (dec_legal_c && (dec_code_c == expected_code(pos))) begin
                        if (pos == LAST_POS) begin
                            pos_d         = '0;
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count + 8'd1;
                        end else begin
                            pos_d = pos + POS_W'(1);
                        end
                    end else begin
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count_d = err_count + ERR_W'(1);
                        end
                        if (is_s_c) begin
                            pos_d = POS_W'(1);
                        end else begin
                            pos_d   = '0;
                            state_d = HUNT;
                        end
                    end
                end
            endcase
        end
        locked_d = (state_d == TRACK);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            letter_code  <= C_BLANK;
            letter_valid <= 1'b0;
            pos          <= '0;
            locked       <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            letter_code  <= letter_code_d;
            letter_valid <= letter_valid_d;
            pos          <= pos_d;
            locked       <= locked_d;
            frame_done   <= frame_done_d;
            frame_count  <= frame_count_d;
            err_count    <= err_count_d;
        end
    end

endmodule
